// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types: request bundle, queue depth, arbiter state.
// Also holds the register-match helper used by the hazard compare.
package wb_arbiter_pkg;

   localparam int WB_XLEN  = 32;
   localparam int WB_DEPTH = 4;

   typedef struct packed {
      logic [4:0]         rd;
      logic [WB_XLEN-1:0] data;
   } wb_req_t;

   typedef enum logic {
      WB_NORMAL = 1'b0,
      WB_DRAIN  = 1'b1
   } wb_state_e;

   function automatic logic rd_match(input logic [4:0] a,
                                     input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result queue: in-order storage, wrap pointers with
// an extra MSB, and a per-slot rd/occupancy view for hazard checks.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DW    = WB_XLEN,
   parameter int DEPTH = WB_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [4:0]            push_rd,
   input  logic [DW-1:0]         push_data,
   input  logic                  pop,
   output logic [4:0]            head_rd,
   output logic [DW-1:0]         head_data,
   output logic [AW:0]           count,
   output logic [DEPTH-1:0]      occ,
   output logic [DEPTH-1:0][4:0] ent_rd
);

   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [4:0]     rd_mem   [DEPTH];
   logic [DW-1:0]  data_mem [DEPTH];

   // Pointers advance on push/pop; MSB separates full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Entry storage; stale contents are masked by occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr[AW-1:0]]   <= push_rd;
         data_mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   assign count     = wr_ptr - rd_ptr;
   assign head_rd   = rd_mem[rd_ptr[AW-1:0]];
   assign head_data = data_mem[rd_ptr[AW-1:0]];

   // A slot is live when its distance from the head is below count.
   always_comb begin
      occ    = '0;
      ent_rd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ[i]    = {1'b0, AW'(AW'(i) - rd_ptr[AW-1:0])} < count;
         ent_rd[i] = rd_mem[i];
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the single-cycle pipe with queued
// long-latency results onto one register-file write port.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = WB_XLEN,
   parameter int DEPTH      = WB_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid_i,
   input  logic [4:0]            alu_rd_i,
   input  logic [DATA_WIDTH-1:0] alu_data_i,
   output logic                  alu_stall_o,
   input  logic                  lsu_valid_i,
   output logic                  lsu_ready_o,
   input  logic [4:0]            lsu_rd_i,
   input  logic [DATA_WIDTH-1:0] lsu_data_i,
   input  logic [4:0]            rs1_addr_i,
   input  logic [4:0]            rs2_addr_i,
   output logic                  rs1_pending_o,
   output logic                  rs2_pending_o,
   output logic                  reg_write_o,
   output logic [4:0]            rd_addr_o,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] HALF = (AW+1)'(DEPTH / 2);

   wb_state_e                state_q;
   wb_state_e                state_d;
   logic [AW:0]              count;
   logic [AW:0]              count_d;
   logic                     push;
   logic                     pop;
   logic                     alu_live;
   logic                     sel_valid;
   logic [4:0]               sel_rd;
   logic [DATA_WIDTH-1:0]    sel_data;
   logic [4:0]               head_rd;
   logic [DATA_WIDTH-1:0]    head_data;
   logic [DEPTH-1:0]         occ;
   logic [DEPTH-1:0][4:0]    ent_rd;

   wb_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_rd   (lsu_rd_i),
      .push_data (lsu_data_i),
      .pop       (pop),
      .head_rd   (head_rd),
      .head_data (head_data),
      .count     (count),
      .occ       (occ),
      .ent_rd    (ent_rd)
   );

   // rd=0 results complete the handshake but are never queued.
   assign lsu_ready_o = count < FULL;
   assign alu_live    = alu_valid_i && (alu_rd_i != 5'd0);
   assign push        = lsu_valid_i && lsu_ready_o && (lsu_rd_i != 5'd0);

   // Port selection, drain-mode stall and NORMAL/DRAIN hysteresis.
   always_comb begin
      state_d     = state_q;
      alu_stall_o = 1'b0;
      pop         = 1'b0;
      sel_valid   = 1'b0;
      sel_rd      = alu_rd_i;
      sel_data    = alu_data_i;
      unique case (state_q)
         WB_NORMAL: begin
            if (alu_live) begin
               sel_valid = 1'b1;
            end else if (count != '0) begin
               pop       = 1'b1;
               sel_valid = 1'b1;
               sel_rd    = head_rd;
               sel_data  = head_data;
            end
         end
         WB_DRAIN: begin
            alu_stall_o = alu_live;
            if (count != '0) begin
               pop       = 1'b1;
               sel_valid = 1'b1;
               sel_rd    = head_rd;
               sel_data  = head_data;
            end
         end
      endcase
      count_d = count + (AW+1)'(push) - (AW+1)'(pop);
      unique case (state_q)
         WB_NORMAL: if (count_d == FULL) state_d = WB_DRAIN;
         WB_DRAIN:  if (count_d <= HALF) state_d = WB_NORMAL;
      endcase
   end

   // Arbiter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= WB_NORMAL;
      else        state_q <= state_d;
   end

   // Registered register-file write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_o <= 1'b0;
         rd_addr_o   <= '0;
         rd_data_o   <= '0;
      end else begin
         reg_write_o <= sel_valid;
         if (sel_valid) begin
            rd_addr_o <= sel_rd;
            rd_data_o <= sel_data;
         end
      end
   end

   // Hazard query against every occupied queue slot, head included.
   always_comb begin
      rs1_pending_o = 1'b0;
      rs2_pending_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occ[i] && rd_match(rs1_addr_i, ent_rd[i])) rs1_pending_o = 1'b1;
         if (occ[i] && rd_match(rs2_addr_i, ent_rd[i])) rs2_pending_o = 1'b1;
      end
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of write-back data.
REQ-002 SHALL have parameter DEPTH, default 4, long-latency result queue entries; power of 2, >=2.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alu_valid_i  input  1  single-cycle pipe result valid.
REQ-006 SHALL have port alu_rd_i  input  5  pipe destination register.
REQ-007 SHALL have port alu_data_i  input  DATA_WIDTH  pipe result.
REQ-008 SHALL have port alu_stall_o  output  1  pipe result not accepted this cycle; producer holds it.
REQ-009 SHALL have port lsu_valid_i  input  1  long-latency (load/mul/div) result valid.
REQ-010 SHALL have port lsu_ready_o  output  1  queue can accept a long-latency result.
REQ-011 SHALL have port lsu_rd_i  input  5  long-latency destination register.
REQ-012 SHALL have port lsu_data_i  input  DATA_WIDTH  long-latency result.
REQ-013 SHALL have port rs1_addr_i, rs2_addr_i  input  5 each  hazard query addresses.
REQ-014 SHALL have port rs1_pending_o, rs2_pending_o  output  1 each  queried register has a queued write.
REQ-015 SHALL have port reg_write_o  output  1  register-file write enable.
REQ-016 SHALL have port rd_addr_o  output  5  register-file write address.
REQ-017 SHALL have port rd_data_o  output  DATA_WIDTH  register-file write data.

Function
REQ-018 SHALL register reg_write_o/rd_addr_o/rd_data_o; a selected write appears exactly 1 cycle after selection, reg_write_o high for exactly 1 cycle per write.
REQ-019 SHALL accept a long-latency result when lsu_valid_i && lsu_ready_o; lsu_ready_o = (count < DEPTH), from registered state only.
REQ-020 SHALL accept-and-discard any result with rd=0 (ALU or LSU): not queued, never issued, no stall.
REQ-021 SHALL run FSM NORMAL/DRAIN; NORMAL: valid ALU result (rd!=0) always selected, alu_stall_o=0; queue head selected only in cycles without one.
REQ-022 SHALL transition NORMAL->DRAIN when count reaches DEPTH; DRAIN->NORMAL when count <= DEPTH/2.
REQ-023 SHALL in DRAIN assert alu_stall_o whenever alu_valid_i, and pop/issue queue head every cycle it is non-empty.
REQ-024 SHALL issue queued results strictly in acceptance order; same-rd writes never reorder within the queue.
REQ-025 SHALL allow enqueue and dequeue in the same cycle (count unchanged); pointers DEPTH-wrap with an extra MSB to distinguish full/empty.
REQ-026 SHALL drive rsN_pending_o combinationally high iff rsN_addr_i != 0 and matches rd of any occupied queue entry (including the head being popped this cycle).
REQ-027 SHALL not assert pending for a write already in the output register (register-file forwarding covers it).

Reset
REQ-028 SHALL on rst_n low, asynchronously: reg_write_o=0, rd_addr_o=0, rd_data_o=0, count=0, pointers=0, FSM=NORMAL; hence lsu_ready_o=1, alu_stall_o=0, pending outputs 0.
REQ-029 SHALL drop all queued entries on reset mid-operation; no write issued in the first cycle after release.

Structure
REQ-030 SHALL place wb_req_t (rd, data) typedef, WB_DEPTH default and FSM state enum in the shared core package.
REQ-031 SHALL implement queue storage/pointers as sub-module wb_fifo (push, pop, head, count, per-entry rd view for hazard compare).

Verification
REQ-032 ALU rd=5 data=0x11 alone -> next cycle reg_write_o=1, rd_addr_o=5, rd_data_o=0x11, then 0.
REQ-033 ALU rd=3 and LSU rd=7 0xAA same cycle -> x3 written next cycle, x7 the cycle after; rs1_addr_i=7 pending=1 until pop.
REQ-034 4 LSU pushes with ALU continuously valid -> DRAIN entered, alu_stall_o=1, two pops then NORMAL, ALU resumes, no write lost.
REQ-035 LSU rd=0 and ALU rd=0 -> no reg_write_o, no queue growth, lsu_ready_o stays 1.
REQ-036 Queue holds 3 entries, rst_n pulsed low mid-cycle -> outputs 0 immediately, no later writes of old entries.
REQ-037 LSU rd=9 0x1 then rd=9 0x2 -> issued in that order; final x9=0x2.
